// File: rtl/branch_history_table.sv
// 2-bit saturating-counter branch history table with a post-reset init sweep.
// Optional `BHT_STATS_EN adds branch / mispredict counters.
module branch_history_table #(
   parameter int unsigned IDX_BITS   = 4,
   parameter logic [1:0]  INIT_STATE = 2'b11
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lookup_valid_i,
   input  logic [31:0] lookup_pc_i,
   output logic [1:0]  state_o,
   output logic        predict_o,
   input  logic        update_valid_i,
   input  logic [31:0] update_pc_i,
   input  logic [1:0]  update_state_i,
   input  logic        update_taken_i,
   output logic        mispredict_o,
   output logic        busy_o
`ifdef BHT_STATS_EN
   ,
   output logic [31:0] stat_branches_o,
   output logic [31:0] stat_mispredicts_o
`endif
);

   localparam int unsigned        ENTRIES  = 2 ** IDX_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX = '1;
   localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e              state_q, state_d;
   logic [IDX_BITS-1:0] init_cnt_q, init_cnt_d;
   logic [1:0]          table_q [ENTRIES];

   logic [IDX_BITS-1:0] lookup_idx, update_idx;
   logic [1:0]          upd_cur, upd_next;
   logic                train_en;

   assign lookup_idx = lookup_pc_i[IDX_BITS+1:2];
   assign update_idx = update_pc_i[IDX_BITS+1:2];
   assign upd_cur    = table_q[update_idx];
   assign train_en   = (state_q == ST_RUN) && update_valid_i;

   always_comb begin
      if (update_taken_i) upd_next = (upd_cur == 2'b11) ? 2'b11 : upd_cur + 2'd1;
      else                upd_next = (upd_cur == 2'b00) ? 2'b00 : upd_cur - 2'd1;
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + IDX_ONE;
         if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // NOTE: the table has no reset; the INIT sweep fills it, keeping reset off every storage flop.
   always_ff @(posedge clk_i) begin
      if (state_q == ST_INIT) table_q[init_cnt_q] <= INIT_STATE;
      else if (update_valid_i) table_q[update_idx] <= upd_next;
   end

   // Write-through: a same-cycle update to the looked-up entry is visible immediately.
   always_comb begin
      if (state_q == ST_INIT)                     state_o = INIT_STATE;
      else if (train_en && lookup_idx == update_idx) state_o = upd_next;
      else                                        state_o = table_q[lookup_idx];
   end

   assign predict_o    = state_o[1];
   assign mispredict_o = update_valid_i && (update_state_i[1] != update_taken_i);
   assign busy_o       = (state_q == ST_INIT);

`ifdef BHT_STATS_EN
   logic [31:0] branches_q, mispredicts_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         branches_q    <= '0;
         mispredicts_q <= '0;
      end else if (train_en) begin
         branches_q <= branches_q + 32'd1;
         if (mispredict_o) mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign stat_branches_o    = branches_q;
   assign stat_mispredicts_o = mispredicts_q;
`endif

   // PC bits outside the index, and the lookup qualifier, are intentionally unused.
   logic unused_bits;
   assign unused_bits = ^{lookup_valid_i, lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0],
                          update_pc_i[31:IDX_BITS+2], update_pc_i[1:0], update_state_i[0]};

endmodule

// File: tb/tb_branch_history_table.sv
// Scoreboard bench for branch_history_table: the driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_branch_history_table;

   localparam int N_ENT = 16;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        lookup_valid_i;
   logic [31:0] lookup_pc_i;
   logic [1:0]  state_o;
   logic        predict_o;
   logic        update_valid_i;
   logic [31:0] update_pc_i;
   logic [1:0]  update_state_i;
   logic        update_taken_i;
   logic        mispredict_o;
   logic        busy_o;
`ifdef BHT_STATS_EN
   logic [31:0] stat_branches_o, stat_mispredicts_o;
`endif

   always #5 clk = ~clk;

   branch_history_table #(.IDX_BITS(4), .INIT_STATE(2'b11)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .lookup_valid_i (lookup_valid_i),
      .lookup_pc_i    (lookup_pc_i),
      .state_o        (state_o),
      .predict_o      (predict_o),
      .update_valid_i (update_valid_i),
      .update_pc_i    (update_pc_i),
      .update_state_i (update_state_i),
      .update_taken_i (update_taken_i),
      .mispredict_o   (mispredict_o),
      .busy_o         (busy_o)
`ifdef BHT_STATS_EN
      ,
      .stat_branches_o    (stat_branches_o),
      .stat_mispredicts_o (stat_mispredicts_o)
`endif
   );

   typedef struct {
      logic [1:0]  st;
      logic        misp;
      logic        busy;
      logic [31:0] nb;
      logic [31:0] nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: counter per index, cycles of init remaining, stat totals.
   int          model [N_ENT];
   int          init_left;
   int unsigned nb, nm;

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % N_ENT);
   endfunction

   function automatic int trained(int cur, bit taken);
      if (taken) return (cur + 1 > 3) ? 3 : cur + 1;
      return (cur - 1 < 0) ? 0 : cur - 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("state_o",      32'(state_o),      32'(mon_e.st));
         check("predict_o",    32'(predict_o),    32'(mon_e.st[1]));
         check("mispredict_o", 32'(mispredict_o), 32'(mon_e.misp));
         check("busy_o",       32'(busy_o),       32'(mon_e.busy));
`ifdef BHT_STATS_EN
         check("stat_branches_o",    stat_branches_o,    mon_e.nb);
         check("stat_mispredicts_o", stat_mispredicts_o, mon_e.nm);
`endif
      end
   end

   // Called at posedge+1: drive one cycle, predict, then advance the model past the edge.
   task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input logic [1:0] ust, input bit utk);
      exp_t e;
      int   li, ui;
      bit   busy;
      lookup_valid_i = lv;  lookup_pc_i    = lpc;
      update_valid_i = uv;  update_pc_i    = upc;
      update_state_i = ust; update_taken_i = utk;
      li   = idx_of(lpc);
      ui   = idx_of(upc);
      busy = (init_left > 0);
      e.busy = busy;
      e.misp = uv && (ust[1] != utk);
      e.nb   = nb;
      e.nm   = nm;
      if (busy)                  e.st = 2'b11;
      else if (uv && li == ui)   e.st = 2'(trained(model[ui], utk));
      else                       e.st = 2'(model[li]);
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (!busy && uv) begin
         model[ui] = trained(model[ui], utk);
         nb++;
         if (e.misp) nm++;
      end
      if (init_left > 0) init_left--;
   endtask

   task automatic do_reset();
      exp_t e;
      rst_i = 1'b1;
      lookup_valid_i = 1'b0; lookup_pc_i = '0;
      update_valid_i = 1'b0; update_pc_i = '0;
      update_state_i = '0;   update_taken_i = 1'b0;
      foreach (model[i]) model[i] = 3;
      nb = 0; nm = 0;
      init_left = N_ENT;
      e.busy = 1'b1; e.st = 2'b11; e.misp = 1'b0; e.nb = 0; e.nm = 0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      rst_i = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      step(1'b1, pc, 1'b0, 32'h0, 2'b00, 1'b0);
   endtask

   task automatic update(input logic [31:0] pc, input logic [1:0] ust, input bit tk);
      step(1'b1, pc, 1'b1, pc, ust, tk);
   endtask

   task automatic random_steps(input int n);
      for (int i = 0; i < n; i++)
         step(1'($urandom), $urandom, 1'($urandom), $urandom, 2'($urandom), 1'($urandom));
   endtask

   initial begin
      rst_i = 1'b1;
      lookup_valid_i = 1'b0; lookup_pc_i = '0;
      update_valid_i = 1'b0; update_pc_i = '0;
      update_state_i = '0;   update_taken_i = 1'b0;
      @(posedge clk); #1;
      do_reset();

      // INIT sweep: training attempts are ignored, mispredict still reported.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h20, 1'b1, 32'h20, 2'b11, 1'b0);
      for (int i = 4; i < N_ENT; i++) lookup(32'(i * 4));
      // All entries strongly taken, including the one trained during INIT.
      for (int i = 0; i < N_ENT; i++) lookup(32'(i * 4));

      // Saturate down at 0x0C, then a mispredicted taken update.
      for (int i = 0; i < 4; i++) update(32'h0C, 2'b11, 1'b0);
      lookup(32'h0C);
      update(32'h0C, 2'b00, 1'b1);
      lookup(32'h0C);

      // Aliasing: 0x04 and 0x44 share an index; 0x08 unaffected.
      update(32'h04, 2'b11, 1'b0);
      lookup(32'h44);
      lookup(32'h08);

      // Write-through bypass at 0x10.
      update(32'h10, 2'b11, 1'b0);
      update(32'h10, 2'b10, 1'b1);
      lookup(32'h10);

      // Five updates, two of them mispredicted.
      update(32'h14, 2'b11, 1'b1);
      update(32'h18, 2'b11, 1'b0);
      update(32'h1C, 2'b01, 1'b0);
      update(32'h24, 2'b00, 1'b1);
      update(32'h28, 2'b10, 1'b1);

      random_steps(400);

      // Reset mid-run: stats clear at once, sweep reruns.
      do_reset();
      random_steps(N_ENT + 40);

      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
- Dynamic branch predictor for the pipelined RISC-V core.
- Sits beside the IF/ID stage. It returns a 2-bit prediction state for the branch being decoded, and that state is carried into ID_EX (the state_o field).
- It is trained by the EX stage once the branch resolves, and it raises the mispredict flush that drives the IF_ID flush input.
- Each entry is a 2-bit saturating counter indexed by the low PC bits.

Parameters:
- IDX_BITS, 4, index width; table holds 2**IDX_BITS entries.
- INIT_STATE, 2'b11, counter value loaded into every entry at reset (strongly taken).

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- rst_i  input  1  asynchronous reset, active-high
- lookup_valid_i  input  1  ID stage holds a conditional branch
- lookup_pc_i  input  32  PC of branch in ID
- state_o  output  2  counter value for lookup_pc_i (to ID_EX)
- predict_o  output  1  state_o[1]; 1 = predict taken
- update_valid_i  input  1  EX stage resolves a conditional branch this cycle
- update_pc_i  input  32  PC of resolving branch
- update_state_i  input  2  state captured at prediction time (from ID_EX)
- update_taken_i  input  1  actual outcome, 1 = taken
- mispredict_o  output  1  update_valid_i && (update_state_i[1] != update_taken_i)
- busy_o  output  1  1 while the post-reset initialization sweep is running

Behaviour:
- **Index.** idx = pc[IDX_BITS+1:2]; pc[1:0] is ignored. Aliasing between PCs that share an index is permitted.

- **Reset.** While rst_i is high, the block asynchronously sets:
  - the FSM to INIT, with init counter = 0
  - state_o = INIT_STATE, predict_o = INIT_STATE[1], mispredict_o = 0, busy_o = 1

- **FSM states.**
  - INIT: one entry is written per cycle with INIT_STATE, at address init_counter, and init_counter increments. The FSM moves to RUN on the cycle after entry 2**IDX_BITS-1 is written, so INIT lasts 2**IDX_BITS cycles after rst_i falls.
  - While in INIT:
    - busy_o = 1
    - state_o = INIT_STATE and predict_o = INIT_STATE[1], regardless of the table contents
    - update_valid_i is ignored for training
    - mispredict_o is still computed, because it is combinational on the inputs
  - RUN: busy_o = 0. Normal operation.

- **Lookup.** Combinational, zero latency. state_o = table[idx(lookup_pc_i)]. When lookup_valid_i = 0, state_o and predict_o still reflect the table value; consumers gate on their own valid signal.

- **Training.** On a rising edge in RUN with update_valid_i = 1, the entry at idx(update_pc_i) is re-read from the table; update_state_i is NOT used for training. The new value is:
  - taken: min(cur+1, 3)
  - not taken: max(cur-1, 0)
  - This saturates: 3 + taken stays 3, and 0 + not taken stays 0.

- **Simultaneous lookup and update, same index.** state_o forwards the post-update value in the same cycle (write-through bypass). With different indices there is no interaction.

- **Mispredict.** mispredict_o is purely combinational from the update_* inputs, in the same cycle that EX resolves. It does not depend on the FSM state.

- **Reset mid-operation.** Any table write in flight is discarded, and the full INIT sweep reruns.

- **Storage.** The table is a register array named table (not memory inference), 2 bits × 2**IDX_BITS.

Optional Feature:
- Macro: BHT_STATS_EN.
- When defined, add two output ports:
  - stat_branches_o [31:0]: counts RUN-state cycles with update_valid_i = 1.
  - stat_mispredicts_o [31:0]: counts RUN-state cycles with update_valid_i && mispredict_o.
- Both counters:
  - clear to 0 on rst_i and stay 0 through INIT
  - wrap at 2**32
  - update on the same edge as training
- When undefined, neither port nor the counters exist, and all other behaviour is identical.

Test Plan:
- **Reset sweep.** Pulse rst_i for 1 cycle with IDX_BITS = 4 → busy_o = 1 for exactly 16 cycles after rst_i falls. Every lookup then returns state_o = 2'b11 and predict_o = 1.
- **Saturate down, then mispredict.** Send 3 not-taken updates to pc = 0x0C; state_o for 0x0C goes 3 → 2 → 1 → 0 and a 4th not-taken leaves it at 0. Then a taken update with update_state_i = 2'b00 → mispredict_o = 1 in that cycle, and the entry becomes 1.
- **Aliasing.** With IDX_BITS = 4, a not-taken update to pc = 0x04 → lookup of pc = 0x44 returns 2'b10. Lookup of pc = 0x08 stays 2'b11.
- **Bypass.** In the same cycle, lookup_pc_i = update_pc_i = 0x10, entry = 2, update taken → state_o reads 3 in that cycle. Afterwards the lookup holds 3.
- **Training blocked during INIT.** Assert update_valid_i with not-taken during INIT → after INIT, the entry still equals INIT_STATE. mispredict_o still follows update_state_i[1] != update_taken_i.
- **Stats (BHT_STATS_EN).** After INIT, 5 updates with 2 mispredicts → stat_branches_o = 5 and stat_mispredicts_o = 2. Assert rst_i mid-run → both counters read 0 immediately.
